fft_sequencer: RTL and testbench
================================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter N_LOG2, default 3, meaning log2 of transform size N (N=8 by default).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a transform; sampled only in IDLE.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  sample-load handshake.
REQ-006 SHALL have port wr_addr  output  N_LOG2  bit-reversed sample-RAM write address during LOAD.
REQ-007 SHALL have ports op_valid output 1, op_ready input 1  butterfly-issue handshake to the datapath.
REQ-008 SHALL have ports addr_a, addr_b output N_LOG2, tw_idx output N_LOG2-1, stage output ceil(log2(N_LOG2))  butterfly operands.
REQ-009 SHALL have port dp_idle  input  1  datapath reports all issued butterflies written back.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, rd_addr output N_LOG2  result-unload handshake.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the last result is accepted.

Function
REQ-012 SHALL implement states IDLE, LOAD, RUN, DRAIN, UNLOAD.
REQ-013 SHALL, in IDLE with start=1, go to LOAD with sample counter cnt=0; start in any other state is ignored.
REQ-014 SHALL assert in_ready only in LOAD; on each cycle with in_valid&in_ready, wr_addr=bitrev(cnt) and cnt increments.
REQ-015 SHALL go LOAD->RUN when the Nth sample is accepted (cnt wraps to 0), setting stage s=0, butterfly index k=0.
REQ-016 SHALL assert op_valid in RUN continuously; operands are combinational from (s,k): half=2^s, pos=k mod half, grp=k>>s, addr_a=(grp<<(s+1))|pos, addr_b=addr_a+half, tw_idx=pos<<(N_LOG2-1-s).
REQ-017 SHALL hold operands stable while op_valid&!op_ready; k increments only on op_valid&op_ready (one butterfly per cycle max).
REQ-018 SHALL, on acceptance of k=N/2-1, go RUN->DRAIN with op_valid=0.
REQ-019 SHALL, in DRAIN with dp_idle=1, advance: if s<N_LOG2-1 then s++, k=0, back to RUN; else to UNLOAD with rd_addr=0 (stage-to-stage RAW hazard protection).
REQ-020 SHALL assert out_valid in UNLOAD; rd_addr increments on out_valid&out_ready in natural order 0..N-1.
REQ-021 SHALL, on acceptance of rd_addr=N-1, pulse done for exactly one cycle and return to IDLE; start in that same cycle is ignored.
REQ-022 SHALL perform all counter arithmetic modulo N with no overflow bits exposed on ports.

Reset
REQ-023 SHALL, on rst=1, enter IDLE and clear cnt, s, k, rd_addr at the next edge, including mid-LOAD/RUN/UNLOAD.
REQ-024 SHALL drive in_ready=0, op_valid=0, out_valid=0, done=0, wr_addr=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, rd_addr=0 during and after reset until state changes.

Configuration
REQ-025 SHALL, with macro FFT_SEQ_INVERSE_EN defined, add input inv (1 bit, latched at start) and output tw_conj (1 bit) equal to the latched inv during RUN, 0 otherwise.
REQ-026 SHALL, without FFT_SEQ_INVERSE_EN, omit inv and tw_conj ports; forward transform only.

Structure
REQ-027 SHALL take the state enum, default N_LOG2 and a bitrev function from shared package fft_pkg.
REQ-028 SHALL place the REQ-016 operand computation in combinational sub-module fft_addr_gen.

Verification
REQ-029 SHALL cover: start, 8 samples with in_valid=1 -> wr_addr sequence 0,4,2,6,1,5,3,7, then RUN.
REQ-030 SHALL cover: op_ready=1, dp_idle=1 -> 12 butterflies; s=0 k=0 -> a=0,b=1,tw=0; s=1 k=1 -> a=1,b=3,tw=2; s=2 k=3 -> a=3,b=7,tw=3.
REQ-031 SHALL cover: op_ready=0 for 3 cycles at s=1 k=2 -> a=4,b=6,tw=0 held stable, k unchanged.
REQ-032 SHALL cover: dp_idle=0 for 5 cycles after stage 0 -> op_valid=0, stage stays 0 until dp_idle=1.
REQ-033 SHALL cover: UNLOAD with out_ready toggling -> rd_addr 0..7 each once, done single pulse after rd_addr=7 accepted, then IDLE.
REQ-034 SHALL cover: rst=1 during RUN at s=1 -> next cycle IDLE, all outputs zero; new start completes a full transform.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg : shared FFT sequencer state type, default size and bit-reverse helper
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int N_LOG2_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

  function automatic int stage_w(input int n_log2);
    return (n_log2 > 1) ? $clog2(n_log2) : 1;
  endfunction

  // Reverses the low 'width' bits of value; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[5'(i)] = value[5'(width - 1 - i)];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_addr_gen : radix-2 DIT butterfly operand addresses and twiddle index from (stage, k)
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT,
  parameter int SW     = stage_w(N_LOG2)
) (
  input  logic [SW-1:0]     s,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_idx
);

  logic [N_LOG2-1:0] w_half;
  logic [N_LOG2-1:0] w_grp;
  logic [N_LOG2-1:0] w_base;
  logic [N_LOG2-2:0] w_mask;
  logic [N_LOG2-2:0] w_pos;
  logic [N_LOG2-2:0] w_sh;

  // pos < half <= N/2, so it always fits in N_LOG2-1 bits
  always_comb begin
    w_half = N_LOG2'(1) << s;
    w_mask = (N_LOG2-1)'(w_half - 1'b1);
    w_pos  = k & w_mask;
    w_grp  = {1'b0, k} >> s;
    w_base = (w_grp << s) << 1;
    addr_a = w_base | {1'b0, w_pos};
    addr_b = addr_a + w_half;
    w_sh   = (N_LOG2-1)'(N_LOG2 - 1) - (N_LOG2-1)'(s);
    tw_idx = w_pos << w_sh;
  end

endmodule
`default_nettype wire

// File: rtl/fft_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_sequencer : in-place radix-2 FFT control (load, staged butterflies, unload).
// Optional macro FFT_SEQ_INVERSE_EN adds inv / tw_conj.  Rev 1.0
// ---------------------------------------------------------------------------
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N_LOG2-1:0]            wr_addr,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [N_LOG2-1:0]            addr_a,
  output logic [N_LOG2-1:0]            addr_b,
  output logic [N_LOG2-2:0]            tw_idx,
  output logic [stage_w(N_LOG2)-1:0]   stage,
  input  logic                         dp_idle,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_LOG2-1:0]            rd_addr,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic                         inv,
  output logic                         tw_conj,
`endif
  output logic                         done
);

  localparam int              SW     = stage_w(N_LOG2);
  localparam logic [SW-1:0]   S_LAST = SW'(N_LOG2 - 1);

  state_t            r_state;
  state_t            w_next;
  logic [N_LOG2-1:0] r_cnt;
  logic [N_LOG2-1:0] r_rd;
  logic [SW-1:0]     r_s;
  logic [N_LOG2-2:0] r_k;
  logic              r_done;
  logic [N_LOG2-1:0] w_a;
  logic [N_LOG2-1:0] w_b;
  logic [N_LOG2-2:0] w_tw;

  fft_addr_gen #(
    .N_LOG2 (N_LOG2),
    .SW     (SW)
  ) u_addr_gen (
    .s      (r_s),
    .k      (r_k),
    .addr_a (w_a),
    .addr_b (w_b),
    .tw_idx (w_tw)
  );

  // r_done blocks a start arriving in the cycle the completion pulse is shown
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    wr_addr   = '0;
    op_valid  = 1'b0;
    addr_a    = '0;
    addr_b    = '0;
    tw_idx    = '0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_done) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        wr_addr  = N_LOG2'(bitrev(32'(r_cnt), N_LOG2));
        if (in_valid && (r_cnt == '1)) w_next = ST_RUN;
      end
      ST_RUN: begin
        op_valid = 1'b1;
        addr_a   = w_a;
        addr_b   = w_b;
        tw_idx   = w_tw;
        if (op_ready && (r_k == '1)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dp_idle) w_next = (r_s == S_LAST) ? ST_UNLOAD : ST_RUN;
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && (r_rd == '1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_s     <= '0;
      r_k     <= '0;
      r_rd    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_UNLOAD) && out_ready && (r_rd == '1);
      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) r_cnt <= '0;
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
              r_s <= '0;
              r_k <= '0;
            end
          end
        end
        ST_RUN: begin
          if (op_ready) r_k <= r_k + 1'b1;
        end
        ST_DRAIN: begin
          // Next stage reads what this one wrote, so wait for write-back
          if (dp_idle) begin
            if (r_s != S_LAST) begin
              r_s <= r_s + 1'b1;
              r_k <= '0;
            end else begin
              r_rd <= '0;
            end
          end
        end
        ST_UNLOAD: begin
          if (out_ready) r_rd <= r_rd + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_SEQ_INVERSE_EN
  logic r_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv <= 1'b0;
    end else if ((r_state == ST_IDLE) && start && !r_done) begin
      r_inv <= inv;
    end
  end

  assign tw_conj = (r_state == ST_RUN) && r_inv;
`endif

  assign stage   = r_s;
  assign rd_addr = r_rd;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_sequencer : directed scoreboard bench for fft_sequencer at N=8
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fft_sequencer;

  localparam int LOGN = 3;
  localparam int N    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] wr_addr;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [1:0] tw_idx;
  logic [1:0] stage;
  logic       dp_idle;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] rd_addr;
  logic       done;
`ifdef FFT_SEQ_INVERSE_EN
  logic       tw_conj;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } op_t;

  op_t opq[$];
  int  addrq[$];

  always #5 clk = ~clk;

  fft_sequencer #(.N_LOG2(LOGN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_addr   (wr_addr),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .dp_idle   (dp_idle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_addr   (rd_addr),
`ifdef FFT_SEQ_INVERSE_EN
    .inv       (1'b0),
    .tw_conj   (tw_conj),
`endif
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timed out", tag);
  endtask

  function automatic int bitrev_model(input int i);
    int r = 0;
    int x = i;
    for (int b = 0; b < LOGN; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Enumerate butterflies group by group; k = grp*half + pos
  task automatic push_stage(input int s);
    int  half = 1 << s;
    int  ngrp = N / (2 * half);
    int  kk   = 0;
    op_t e;
    for (int g = 0; g < ngrp; g++) begin
      for (int p = 0; p < half; p++) begin
        e.s  = s;
        e.k  = kk;
        e.a  = g * 2 * half + p;
        e.b  = e.a + half;
        e.tw = p * ngrp;
        opq.push_back(e);
        kk++;
      end
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_op_valid"},  op_valid,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_done"},      done,      0);
    check({tag, "_wr_addr"},   wr_addr,   0);
    check({tag, "_addr_a"},    addr_a,    0);
    check({tag, "_addr_b"},    addr_b,    0);
    check({tag, "_tw_idx"},    tw_idx,    0);
    check({tag, "_stage"},     stage,     0);
    check({tag, "_rd_addr"},   rd_addr,   0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 0);
  endtask

  task automatic do_load(input int gap_mod, input bit start_hold);
    int budget = 0;
    for (int i = 0; i < N; i++) addrq.push_back(bitrev_model(i));
    while (addrq.size() > 0 && budget < 50) begin
      @(negedge clk);
      budget++;
      start    = start_hold;
      in_valid = (gap_mod == 0) || ((budget % gap_mod) != 0);
      #1;
      check("load_in_ready", in_ready, 1);
      if (in_valid) check("wr_addr", wr_addr, addrq.pop_front());
      else          check("wr_addr_hold", wr_addr, addrq[0]);
    end
    if (addrq.size() > 0) begin
      timeout("load");
      addrq.delete();
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_phase(input int stall_n, input int idle_delay, input bit stop_s1,
                           output bit stopped);
    op_t e;
    int  stall_left;
    int  budget;
    stopped = 1'b0;
    for (int s = 0; s < LOGN; s++) begin
      push_stage(s);
      stall_left = (s == 1) ? stall_n : 0;
      budget     = 0;
      while (opq.size() > 0 && budget < 100) begin
        @(negedge clk);
        budget++;
        e        = opq[0];
        op_ready = !(stall_left > 0 && e.k == 2);
        #1;
        check("op_valid", op_valid, 1);
        check("run_in_ready", in_ready, 0);
        check("stage", stage, e.s);
        check("addr_a", addr_a, e.a);
        check("addr_b", addr_b, e.b);
        check("tw_idx", tw_idx, e.tw);
        if (e.s == 0 && e.k == 0) check("lit_s0k0", {addr_a, addr_b, tw_idx}, {3'd0, 3'd1, 2'd0});
        if (e.s == 1 && e.k == 1) check("lit_s1k1", {addr_a, addr_b, tw_idx}, {3'd1, 3'd3, 2'd2});
        if (e.s == 1 && e.k == 2) check("lit_s1k2", {addr_a, addr_b, tw_idx}, {3'd4, 3'd6, 2'd0});
        if (e.s == 2 && e.k == 3) check("lit_s2k3", {addr_a, addr_b, tw_idx}, {3'd3, 3'd7, 2'd3});
        if (stop_s1 && s == 1) begin
          stopped = 1'b1;
          return;
        end
        if (op_ready) void'(opq.pop_front());
        else          stall_left--;
      end
      if (opq.size() > 0) begin
        timeout("run");
        opq.delete();
      end
      for (int c = 0; c <= ((s == 0) ? idle_delay : 0); c++) begin
        @(negedge clk);
        dp_idle = (c == ((s == 0) ? idle_delay : 0));
        #1;
        check("drain_op_valid", op_valid, 0);
        check("drain_stage", stage, s);
      end
    end
  endtask

  task automatic do_unload(input bit toggle);
    int budget = 0;
    for (int i = 0; i < N; i++) addrq.push_back(i);
    while (addrq.size() > 0 && budget < 50) begin
      @(negedge clk);
      budget++;
      out_ready = !toggle || ((budget % 2) == 1);
      #1;
      check("out_valid", out_valid, 1);
      check("unload_done", done, 0);
      if (out_ready) check("rd_addr", rd_addr, addrq.pop_front());
      else           check("rd_addr_hold", rd_addr, addrq[0]);
    end
    if (addrq.size() > 0) begin
      timeout("unload");
      addrq.delete();
    end
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b1;
    #1;
    check("done_pulse", done, 1);
    check("done_out_valid", out_valid, 0);
    check("done_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("done_cleared", done, 0);
    check("start_ignored", in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stopped;
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    op_ready  = 1'b1;
    dp_idle   = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_check("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_check("post_rst");

    // Transform 1: gapped load, 3-cycle stall at s=1 k=2, 5-cycle drain hold after stage 0
    do_start();
    do_load(3, 1'b0);
    run_phase(3, 5, 1'b0, stopped);
    do_unload(1'b1);

    // Transform 2: reset while running stage 1
    do_start();
    do_load(0, 1'b0);
    run_phase(0, 0, 1'b1, stopped);
    check("reached_s1", stopped, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    #1;
    reset_check("rst_run");
    opq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_check("rst_run_idle");

    // Transform 3: start held high through load, no stalls
    do_start();
    do_load(0, 1'b1);
    run_phase(0, 0, 1'b0, stopped);
    do_unload(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
